updown_counter_chain: RTL
=========================

Name: updown_counter_chain

Overview:
Parametrised multi-digit modulo up/down counter with a direction select and a registered wrap carry. Each digit counts 0..MODULUS-1 and ripples to the next digit synchronously within a single clock. The block adds enable, synchronous clear, parallel load with range check, per-digit carries and a combinational terminal-count output for cascading instances. It is the reusable counting core for timers, display counters and event counters in the design.

Parameters:
DIGITS, 2, number of cascaded digits (1..8)
MODULUS, 10, states per digit, values 0..MODULUS-1 (2..2^WIDTH)
WIDTH, 4, bits per digit

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
en  in  1  count enable for one step per clock
up  in  1  direction: 1 = increment, 0 = decrement
clr  in  1  synchronous clear to zero
load  in  1  synchronous parallel load
load_val  in  DIGITS*WIDTH  load value; digit i at bits [i*WIDTH +: WIDTH]
count  out  DIGITS*WIDTH  current value, same packing as load_val
digit_carry  out  DIGITS  registered; bit i pulses when digit i wrapped on the last edge
carry  out  1  registered; pulses when the whole chain wrapped on the last edge
tc  out  1  combinational; en & all digits at terminal value for the current direction
load_err  out  1  registered; pulses when the last load held an out-of-range digit

Behaviour:
- Reset (async, any time, including mid-count): count=0, digit_carry=0, carry=0, load_err=0. The first count happens on the first rising edge after rst falls.
- Priority per edge: clr > load > en. With none of these asserted, count holds.
- clr: count=0. digit_carry, carry and load_err are all 0 on the next cycle.
- load: each digit d = load_val slice. If d >= MODULUS, that digit loads 0 and load_err=1 for exactly one cycle. Loading never produces carry or digit_carry.
- Terminal value per digit: MODULUS-1 when up=1; 0 when up=0.
- Digit 0 steps when en=1.
- Digit i>0 steps when en=1 and digits 0..i-1 are all at the terminal value. All stepping digits update on the same edge, so there is no multi-cycle ripple.
- Step up: a digit at MODULUS-1 wraps to 0; otherwise it increments by 1.
- Step down: a digit at 0 wraps to MODULUS-1; otherwise it decrements by 1.
- digit_carry[i] = 1 in the cycle after digit i wrapped, coincident with the wrapped value appearing on count. It is 0 on every other cycle.
- carry = digit_carry[DIGITS-1] condition: the full chain went from all-terminal to the wrapped value. Up: all MODULUS-1 -> all 0. Down: all 0 -> all MODULUS-1. It is a one-cycle pulse; continuous counting through repeated wraps gives one pulse per wrap.
- tc is purely combinational from en, up and count, with zero latency. Cascading: connect the next instance's en to this instance's tc, sharing up.
- A direction change takes effect on the next enabled edge with no extra state. Example: up at 99 with up->0 in the same cycle steps to 98, and no carry is produced.
- en=0: count holds, and carry and digit_carry are 0.
- Internal digit registers never hold a value >= MODULUS.

Test Plan:
1. DIGITS=2, MODULUS=10. Reset, then en=1, up=1 for 100 clocks -> count follows 00..99 then 00. carry=1 for exactly the one cycle where count=00 after 99. digit_carry[0] pulses 10 times.
2. Load 8'h00, then en=1, up=0 -> next edge count=8'h99 and carry=1. The following edge gives 8'h98 and carry=0. tc=1 while count=00, en=1, up=0.
3. Load 8'h3A -> count=8'h30 and load_err=1 for one cycle, carry=0. Load 8'h45 -> count=8'h45, load_err=0.
4. clr=1, load=1, en=1 together with count=57 -> count=00, no carry. Then load=1, en=1 with load_val=8'h12 -> count=12 (load wins over en).
5. Count up to 8'h42, deassert rst-free hold en=0 for 5 clocks -> count stays 42 and carry stays 0. Assert rst asynchronously mid-cycle -> count=00 immediately, before the next clk edge.
6. At count=8'h99 with up=1, toggle up=0 on the same edge -> count=8'h98 and carry=0. With MODULUS=12, WIDTH=4, DIGITS=1, counting up -> 0..11 then 0, with carry on each wrap.

Source files
------------

// File: rtl/updown_counter_chain.sv
// Multi-digit modulo up/down counter with single-edge ripple, load range check and cascade terminal count.
// Latency: count, digit_carry, carry and load_err are registered (1 clk); tc is combinational (0 clk).
// Backpressure: none; en is the only flow control, and tc drives the en of a cascaded instance.
module updown_counter_chain #(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 10,
  parameter int WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGITS*WIDTH-1:0]   load_val,
  output logic [DIGITS*WIDTH-1:0]   count,
  output logic [DIGITS-1:0]         digit_carry,
  output logic                      carry,
  output logic                      tc,
  output logic                      load_err
);

  localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] digit_q   [DIGITS];
  logic [WIDTH-1:0] digit_nxt [DIGITS];
  logic [WIDTH-1:0] load_dig  [DIGITS];
  logic [DIGITS-1:0] at_term;
  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] wrap;
  logic [DIGITS-1:0] load_bad;

  // Terminal detection per digit and the enable chain: a digit steps only when every lower digit is terminal.
  always_comb begin
    at_term = '0;
    step    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      at_term[i] = up ? (digit_q[i] == LAST) : (digit_q[i] == '0);
    end
    step[0] = en;
    for (int i = 1; i < DIGITS; i++) begin
      step[i] = step[i-1] & at_term[i-1];
    end
    wrap = step & at_term;
  end

  // Next value of every digit on a count step, plus the range-checked load value.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      digit_nxt[i] = digit_q[i];
      load_dig[i]  = load_val[i*WIDTH +: WIDTH];
      load_bad[i]  = ({1'b0, load_val[i*WIDTH +: WIDTH]} >= MOD_EXT);
      if (load_bad[i]) begin
        load_dig[i] = '0;
      end
      if (wrap[i]) begin
        digit_nxt[i] = up ? '0 : LAST;
      end else if (step[i]) begin
        digit_nxt[i] = up ? (digit_q[i] + WIDTH'(1)) : (digit_q[i] - WIDTH'(1));
      end
    end
  end

  // Pack the digit registers onto the output bus, digit 0 in the low bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < DIGITS; i++) begin
      count[i*WIDTH +: WIDTH] = digit_q[i];
    end
  end

  // Cascade output: the next instance steps on the same edge this one wraps.
  assign tc = en & (&at_term);

  // State update with priority clr > load > en; all flag outputs are one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= '0;
      end
      digit_carry <= '0;
      carry       <= 1'b0;
      load_err    <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= '0;
      end
      digit_carry <= '0;
      carry       <= 1'b0;
      load_err    <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= load_dig[i];
      end
      digit_carry <= '0;
      carry       <= 1'b0;
      load_err    <= |load_bad;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_q[i] <= digit_nxt[i];
      end
      digit_carry <= wrap;
      carry       <= wrap[DIGITS-1];
      load_err    <= 1'b0;
    end
  end

endmodule
